// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot core's framebuffer write path.
package mandel_pkg;

   localparam int FB_BUS_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      PTR_RST,
      SETUP,
      STROBE,
      GAP
   } fbw_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fb_write_serializer_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear.
// Reads are fall-through: rd_data always shows the head entry.
module sync_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic                         push,
   input  logic [W-1:0]                 wr_data,
   input  logic                         pop,
   output logic [W-1:0]                 rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         // Power-of-two depth lets the pointers wrap naturally.
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
   end

   // NOTE: the storage array has no reset; an entry is only visible once level says it was written.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/fb_write_serializer.sv
// Framebuffer write port: buffers pixel words and serialises them onto the
// narrow external bus with programmable strobe/gap timing.
module fb_write_serializer
   import mandel_pkg::*;
#(
   parameter int DATA_W        = 4,
   parameter int BUS_W         = FB_BUS_W,
   parameter int DEPTH         = 4,
   parameter int STROBE_CYCLES = 1,
   parameter int GAP_CYCLES    = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_sof,
   input  logic                         abort,
   output logic [BUS_W-1:0]             mem_data,
   output logic                         mem_write,
   output logic                         mem_reset_ptr,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

   localparam int BEATS  = DATA_W / BUS_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CYC_W  = max_int(1, max_int($clog2(STROBE_CYCLES), $clog2(GAP_CYCLES)));

   if (DATA_W % BUS_W != 0) begin : g_bad_width
      $error("fb_write_serializer: DATA_W must be a multiple of BUS_W");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fb_write_serializer: DEPTH must be a power of two and at least 2");
   end
   if ((STROBE_CYCLES < 1) || (GAP_CYCLES < 1)) begin : g_bad_timing
      $error("fb_write_serializer: STROBE_CYCLES and GAP_CYCLES must be at least 1");
   end

   fbw_state_t        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
   logic [BUS_W-1:0]  mem_data_q, mem_data_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_reset_ptr_q, mem_reset_ptr_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W:0]   fifo_rd_data;

   // No credit for a same-cycle pop: readiness depends only on current occupancy.
   assign in_ready  = ~fifo_full & ~abort & ~rst;
   assign fifo_push = in_valid & in_ready;

   sync_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .clear   (rst | abort),
      .push    (fifo_push),
      .wr_data ({in_sof, in_data}),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fill_level)
   );

   // Bus outputs are registered copies of what the current state drives, one cycle later.
   always_comb begin
      state_d         = state_q;
      shift_d         = shift_q;
      beat_cnt_d      = beat_cnt_q;
      cyc_cnt_d       = cyc_cnt_q;
      fifo_pop        = 1'b0;
      mem_data_d      = mem_data_q;
      mem_write_d     = (state_q == STROBE);
      mem_reset_ptr_d = (state_q == PTR_RST);

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_d    = fifo_rd_data[DATA_W-1:0];
               beat_cnt_d = '0;
               state_d    = fifo_rd_data[DATA_W] ? PTR_RST : SETUP;
            end
         end
         PTR_RST: state_d = SETUP;
         SETUP: begin
            mem_data_d = shift_q[BUS_W-1:0];
            shift_d    = shift_q >> BUS_W;
            cyc_cnt_d  = CYC_W'(STROBE_CYCLES - 1);
            state_d    = STROBE;
         end
         STROBE: begin
            if (cyc_cnt_q == '0) begin
               cyc_cnt_d = CYC_W'(GAP_CYCLES - 1);
               state_d   = GAP;
            end else begin
               cyc_cnt_d = cyc_cnt_q - CYC_W'(1);
            end
         end
         GAP: begin
            if (cyc_cnt_q != '0) begin
               cyc_cnt_d = cyc_cnt_q - CYC_W'(1);
            end else if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
               state_d = IDLE;
            end else begin
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               state_d    = SETUP;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort abandons any partial word and parks the bus at zero.
      if (abort) begin
         state_d         = IDLE;
         fifo_pop        = 1'b0;
         mem_data_d      = '0;
         mem_write_d     = 1'b0;
         mem_reset_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         shift_q         <= '0;
         beat_cnt_q      <= '0;
         cyc_cnt_q       <= '0;
         mem_data_q      <= '0;
         mem_write_q     <= 1'b0;
         mem_reset_ptr_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         shift_q         <= shift_d;
         beat_cnt_q      <= beat_cnt_d;
         cyc_cnt_q       <= cyc_cnt_d;
         mem_data_q      <= mem_data_d;
         mem_write_q     <= mem_write_d;
         mem_reset_ptr_q <= mem_reset_ptr_d;
      end
   end

   assign mem_data      = mem_data_q;
   assign mem_write     = mem_write_q;
   assign mem_reset_ptr = mem_reset_ptr_q;
   assign busy          = (state_q != IDLE) | ~fifo_empty;

endmodule
